// File: rtl/bp_me_pkg.sv
// Shared declarations for the LCE request arbiter: output register state
// and the counter-width helper used for the per-requester credit counts.
package bp_me_pkg;

    typedef enum logic {
        e_empty = 1'b0,
        e_full  = 1'b1
    } bp_lce_req_state_e;

    // Bits needed to hold 0..x inclusive
    function automatic int bsg_width(input int x);
        return $clog2(x + 1);
    endfunction

endpackage

// File: rtl/bp_lce_req_rr_arb.sv
// Round-robin picker: one-hot grant to the first valid index at or after the
// pointer; the pointer moves just past the winner only when grant_v_i is set.
module bp_lce_req_rr_arb
    import bp_me_pkg::*;
#(
    parameter int num_req_p = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [num_req_p-1:0] v_i,
    input  logic                 grant_v_i,
    output logic [num_req_p-1:0] grants_o
);

    localparam int ptr_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    logic [ptr_w-1:0] ptr_r;
    logic [ptr_w-1:0] win_idx;
    logic             found;

    // Outer loop walks priority order from the pointer; inner loop keeps every
    // bit select on a constant index.
    always_comb begin
        grants_o = '0;
        win_idx  = ptr_r;
        found    = 1'b0;
        for (int k = 0; k < num_req_p; k++) begin
            for (int i = 0; i < num_req_p; i++) begin
                if (!found && v_i[i] && (((int'(ptr_r) + k) % num_req_p) == i)) begin
                    found       = 1'b1;
                    grants_o[i] = 1'b1;
                    win_idx     = ptr_w'(i);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_r <= '0;
        end else if (grant_v_i && found) begin
            ptr_r <= (win_idx == ptr_w'(num_req_p - 1)) ? '0 : win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/bp_lce_req_arbiter.sv
// Shares one LCE request network port among several LCE sources with
// round-robin arbitration, per-requester credit limits and a one-entry output.
module bp_lce_req_arbiter
    import bp_me_pkg::*;
#(
    parameter int num_req_p   = 2,
    parameter int req_width_p = 64,
    parameter int credits_p   = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_req_p*req_width_p-1:0] req_i,
    input  logic [num_req_p-1:0]             req_v_i,
    output logic [num_req_p-1:0]             req_yumi_o,
    input  logic [num_req_p-1:0]             credit_return_i,
    output logic [num_req_p-1:0]             credits_full_o,
    output logic [num_req_p-1:0]             credits_empty_o,
    output logic [req_width_p-1:0]           lce_req_o,
    output logic                             lce_req_v_o,
    input  logic                             lce_req_ready_i
);

    localparam int cnt_w = bsg_width(credits_p);

    bp_lce_req_state_e state_r, state_n;

    logic [num_req_p-1:0]   eligible;
    logic [num_req_p-1:0]   grants;
    logic                   can_accept;
    logic                   grant;
    logic [req_width_p-1:0] msg_sel;
    logic [req_width_p-1:0] msg_r;

    assign eligible   = req_v_i & ~credits_full_o;
    assign can_accept = (state_r == e_empty) | lce_req_ready_i;
    // Held off while reset is asserted so no requester sees an accept
    assign grant      = reset_n_i & can_accept & (|eligible);
    assign req_yumi_o = grant ? grants : '0;

    bp_lce_req_rr_arb #(
        .num_req_p(num_req_p)
    ) rr_arb (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (eligible),
        .grant_v_i(grant),
        .grants_o (grants)
    );

    always_comb begin
        msg_sel = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (grants[i]) begin
                msg_sel = msg_sel | req_i[i*req_width_p +: req_width_p];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_empty;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_empty: if (grant) state_n = e_full;
            e_full:  if (lce_req_ready_i && !grant) state_n = e_empty;
            default: state_n = e_empty;
        endcase
    end

    always_comb begin
        lce_req_v_o = (state_r == e_full);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            msg_r <= '0;
        end else if (grant) begin
            msg_r <= msg_sel;
        end
    end

    assign lce_req_o = msg_r;

    for (genvar i = 0; i < num_req_p; i++) begin : g_cred
        logic [cnt_w-1:0] count_r;
        logic             inc;
        logic             dec;

        assign inc = req_yumi_o[i];
        // A return with nothing outstanding is dropped
        assign dec = credit_return_i[i] & (count_r != '0);

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                count_r <= '0;
            end else if (inc && !dec) begin
                count_r <= count_r + 1'b1;
            end else if (!inc && dec) begin
                count_r <= count_r - 1'b1;
            end
        end

        assign credits_full_o[i]  = (count_r == cnt_w'(credits_p));
        assign credits_empty_o[i] = (count_r == '0);

        spurious_return: assert property (@(posedge clk_i) disable iff (!reset_n_i)
            !(credit_return_i[i] && (count_r == '0)))
            else $warning("credit return with no outstanding request on requester %0d", i);
    end

endmodule

// File: tb/tb_bp_lce_req_arbiter.sv
// Bench for bp_lce_req_arbiter: directed scenarios plus random traffic, every
// cycle compared against a transaction-level model of the arbitration rules.
module tb_bp_lce_req_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 16;
    localparam int CRED = 4;

    logic              clk;
    logic              rst_n;
    logic [NREQ*W-1:0] req;
    logic [W-1:0]      d [NREQ];
    logic [NREQ-1:0]   req_v;
    logic [NREQ-1:0]   yumi;
    logic [NREQ-1:0]   ret;
    logic [NREQ-1:0]   full;
    logic [NREQ-1:0]   empty;
    logic [W-1:0]      lce_msg;
    logic              lce_v;
    logic              ready;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: outstanding count per requester, rr pointer, output slot
    int         m_cnt [NREQ];
    int         m_ptr;
    bit         m_v;
    logic [W-1:0] m_data;
    int         m_win;

    bp_lce_req_arbiter #(
        .num_req_p  (NREQ),
        .req_width_p(W),
        .credits_p  (CRED)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (rst_n),
        .req_i          (req),
        .req_v_i        (req_v),
        .req_yumi_o     (yumi),
        .credit_return_i(ret),
        .credits_full_o (full),
        .credits_empty_o(empty),
        .lce_req_o      (lce_msg),
        .lce_req_v_o    (lce_v),
        .lce_req_ready_i(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) req[i*W +: W] = d[i];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        m_ptr  = 0;
        m_v    = 1'b0;
        m_data = '0;
        m_win  = -1;
    endtask

    // Entered 1 time unit after a rising edge with inputs already applied
    task automatic tick();
        int win;
        bit dec [NREQ];
        logic [NREQ-1:0] ey, ef, ee;
        #2;
        win = -1;
        if (rst_n && (!m_v || ready)) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (win < 0 && req_v[i] && m_cnt[i] < CRED) win = i;
            end
        end
        ey = (win >= 0) ? (NREQ'(1) << win) : '0;
        for (int i = 0; i < NREQ; i++) begin
            ef[i] = (m_cnt[i] == CRED);
            ee[i] = (m_cnt[i] == 0);
        end
        chk("yumi", 64'(yumi), 64'(ey));
        chk("lce_v", 64'(lce_v), 64'(m_v));
        if (m_v) chk("lce_msg", 64'(lce_msg), 64'(m_data));
        chk("credits_full", 64'(full), 64'(ef));
        chk("credits_empty", 64'(empty), 64'(ee));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
            win = -1;
        end else begin
            for (int i = 0; i < NREQ; i++) dec[i] = ret[i] && (m_cnt[i] > 0);
            for (int i = 0; i < NREQ; i++) begin
                if (win == i) m_cnt[i]++;
                if (dec[i]) m_cnt[i]--;
            end
            if (win >= 0) begin
                m_v    = 1'b1;
                m_data = d[win];
                m_ptr  = (win + 1) % NREQ;
            end else if (ready) begin
                m_v = 1'b0;
            end
        end
        m_win = win;
        #1;
        // Granted requester moves on to a fresh message
        if (win >= 0) d[win] = W'($urandom);
    endtask

    task automatic drain_credits();
        req_v = '0;
        ready = 1'b1;
        for (int n = 0; n < 4 * CRED + 4; n++) begin
            for (int i = 0; i < NREQ; i++) ret[i] = (m_cnt[i] > 0);
            tick();
        end
        ret = '0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req_v = 2'b11;
        ret   = '0;
        ready = 1'b0;
        for (int i = 0; i < NREQ; i++) d[i] = W'($urandom);
        model_reset();
        @(posedge clk);
        #1;

        // Reset state, including no accept while requests are presented
        chk("reset_msg", 64'(lce_msg), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        req_v = '0;
        tick();
        tick();

        // Both requesters streaming with a ready network
        req_v = 2'b11;
        ready = 1'b1;
        repeat (4) tick();
        req_v = '0;
        tick();
        drain_credits();

        // Backpressure: hold message A for five cycles, then release
        req_v = 2'b01;
        ready = 1'b1;
        tick();
        req_v = 2'b11;
        ready = 1'b0;
        repeat (5) tick();
        ready = 1'b1;
        tick();
        drain_credits();

        // Credit exhaustion on requester 0, then a single return
        req_v = 2'b01;
        repeat (CRED) tick();
        chk("full0", 64'(full[0]), 64'd1);
        req_v = 2'b11;
        repeat (3) tick();
        ret = 2'b01;
        tick();
        ret = '0;
        tick();
        drain_credits();

        // Grant and return together on requester 1, then a spurious return
        req_v = 2'b10;
        tick();
        ret = 2'b10;
        tick();
        req_v = '0;
        tick();
        tick();
        ret = '0;
        tick();

        // Build counts 3/1 with the output register full, then async reset
        req_v = 2'b01;
        ready = 1'b1;
        repeat (3) tick();
        req_v = 2'b10;
        tick();
        req_v = 2'b11;
        ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_lce_v", 64'(lce_v), 64'd0);
        chk("async_empty", 64'(empty), 64'(2'b11));
        chk("async_yumi", 64'(yumi), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        tick();
        chk("post_reset_first_grant", 64'(m_win), 64'd0);
        req_v = '0;
        tick();
        drain_credits();

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            ready = ($urandom % 4) != 0;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_v[i]) begin
                    req_v[i] = 1'($urandom % 2);
                    d[i]     = W'($urandom);
                end else if (m_win == i) begin
                    req_v[i] = 1'($urandom % 2);
                end
                ret[i] = (m_cnt[i] > 0) && (($urandom % 3) == 0);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bp_lce_req_arbiter.md
Name: bp_lce_req_arbiter

Overview:
- Shares one coherence-network LCE request port among num_req_p LCE request sources, e.g. I$ LCE and D$ LCE on one tile.
- Round-robin arbitration; a requester is ineligible while its outstanding-request credits are full.
- Granted message goes into a single-entry output register with a valid->ready handshake toward the network.
- Tracks per-requester outstanding transactions and exposes per-requester credits_full/credits_empty status.

Parameters:
- num_req_p, 2, number of requesting LCE sources (>=2).
- req_width_p, lce_cce_req_width, width of one LCE request message in bits.
- credits_p, coh_noc_max_credits_p, maximum outstanding requests per requester (>=1).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; one clock, reset is asynchronous and active-low.
- req_i  in  num_req_p*req_width_p  request messages; slice i belongs to requester i.
- req_v_i  in  num_req_p  per-requester valid.
- req_yumi_o  out  num_req_p  per-requester accept; one-hot or zero.
- credit_return_i  in  num_req_p  one-cycle pulse per completed transaction of requester i.
- credits_full_o  out  num_req_p  count[i]==credits_p.
- credits_empty_o  out  num_req_p  count[i]==0.
- lce_req_o  out  req_width_p  registered output message.
- lce_req_v_o  out  1  output valid.
- lce_req_ready_i  in  1  network ready.

Behaviour:
- Reset (async assert, sync deassert):
  - Output register empty: lce_req_v_o=0, lce_req_o=0.
  - req_yumi_o=0, all counts 0, so credits_empty_o all 1 and credits_full_o all 0.
  - Round-robin pointer=0.
- Output FSM, states e_empty and e_full:
  - e_empty: if a grant occurs, load the register and go to e_full.
  - e_full: if lce_req_ready_i and a grant occurs, reload and stay in e_full. If lce_req_ready_i and no grant, go to e_empty. If not ready, hold the register contents unchanged.
- Requester handshake:
  - Requester i is eligible when req_v_i[i] & ~credits_full_o[i].
  - can_accept = (state==e_empty) | lce_req_ready_i.
  - Grant occurs when can_accept and at least one requester is eligible.
  - Winner: first eligible index starting at the pointer, ascending with wrap to 0.
  - req_yumi_o[winner]=1 in the grant cycle (combinational). Requesters must hold req_v_i and data stable until yumi.
  - After a grant to i, pointer <= (i+1) mod num_req_p. Pointer is unchanged when there is no grant.
- Latency: message appears on lce_req_o in the cycle after yumi. Back-to-back throughput is 1 message per cycle while lce_req_ready_i=1.
- Credits, per requester:
  - count[i] +1 on yumi[i] and -1 on credit_return_i[i]. Both in the same cycle: unchanged.
  - Counter width `BSG_WIDTH(credits_p).
  - Return while count==0: ignored; simulation assertion fires.
  - Yumi at count==credits_p is impossible, since the requester is ineligible.
- Full-credit requesters are skipped without moving the pointer past them unless another requester wins.
- Reset asserted mid-operation: the held message is discarded, counts clear, no output on lce_req_v_o.
- lce_req_v_o, once asserted, stays high with stable lce_req_o until lce_req_ready_i=1.

Decomposition:
- Shared package (bp_me_pkg): output FSM state enum {e_empty, e_full}. Message struct/width macros come from existing bp_lce_cce_if declarations; no new constants.
- Sub-module bp_lce_req_rr_arb: parametrized num_req_p round-robin picker with v_i vector, grant_v_i (advance enable), one-hot grants_o, and internal pointer on the same async active-low reset. Credit counters stay inline, one per requester.

Test Plan:
- Reset then idle: all outputs match reset values; credits_empty_o=2'b11; no yumi with req_v_i=0.
- Both requesters valid continuously, lce_req_ready_i=1, credits_p=4:
  - yumi alternates 0,1,0,1; one output per cycle starting the cycle after the first yumi.
  - After 4 cycles, counts are 2/2.
- Backpressure: output holding msg A, lce_req_ready_i=0 for 5 cycles:
  - lce_req_o=A stable; no yumi while full.
  - Ready rises: A handshakes, next message B is loaded that same cycle.
- Credit exhaustion, credits_p=2: requester 0 issues 2, no returns:
  - credits_full_o[0]=1; only requester 1 granted.
  - One credit_return_i[0] pulse makes requester 0 eligible next cycle.
- Simultaneous grant and return for requester 1 at count=1: count stays 1; spurious return at count=0 leaves the count at 0 and the assertion fires.
- Reset_n_i pulsed low asynchronously while e_full with counts 3/1: lce_req_v_o drops immediately; counts 0; the first post-reset grant goes to requester 0.
